// File: rtl/riscv_pipe_stage_reg.sv
// riscv_pipe_stage_reg
//   Pipeline stage register with a valid/ready handshake and a two-entry skid
//   buffer. The main slot drives o_data, and the skid slot absorbs the one
//   beat that arrives after downstream stalls. Ready and valid are decoded
//   from registered state only, so there is no combinational path from
//   i_ready to o_ready. The block also keeps a saturating stall-cycle counter.
//
// Ports
//   i_clk, i_rstn      clock, synchronous active-low reset
//   i_clr              flush: empties the stage and drops the incoming beat
//   i_valid/o_ready    upstream handshake, i_data upstream payload
//   o_valid/i_ready    downstream handshake, o_data payload (main slot)
//   o_occupancy        number of held entries (0..2)
//   o_stall_cnt        cycles with o_valid & !i_ready, saturating
module riscv_pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_clr,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // The encoding equals the occupancy, so o_occupancy is the state itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic [CNT_W-1:0]  stall_q;
    logic              accept, pop;

    assign o_valid     = (state != S_EMPTY);
    assign o_ready     = (state != S_FULL);
    assign o_data      = main_q;
    assign o_occupancy = state;
    assign o_stall_cnt = stall_q;

    assign accept = i_valid & o_ready;
    assign pop    = o_valid & i_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    main_nxt  = i_data;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    main_nxt = i_data;
                end else if (accept) begin
                    // Main stays put and is older than the skid entry.
                    skid_nxt  = i_data;
                    state_nxt = S_FULL;
                end else if (pop) begin
                    // Main keeps its stale value; o_valid=0 hides it.
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // o_ready is low here, so only a pop can move the state.
                if (pop) begin
                    main_nxt  = skid_q;
                    state_nxt = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        // A flush overrides everything, including a same-cycle accept.
        if (i_clr) begin
            state_nxt = S_EMPTY;
            main_nxt  = RESET_VALUE;
            skid_nxt  = RESET_VALUE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state  <= S_EMPTY;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // The counter ignores flush. It counts a stalled cycle even while clearing.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule
